// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner. The display word is shadowed at
// frame boundaries, so a mid-scan change never tears the frame shown.
module seg_scan #(
  parameter int SCAN_DIV   = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] display,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp,
  output logic [6:0]  seg,
  output logic        dp_out,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int             PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_INV  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]     AN_INV   = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic           DP_INV   = ACTIVE_LOW;

  logic [PW-1:0] prescaler_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   shadow_code_reg;
  logic [3:0]    shadow_blank_reg;
  logic [3:0]    shadow_dp_reg;
  logic [6:0]    seg_reg;
  logic          dp_out_reg;
  logic [3:0]    an_reg;
  logic          frame_done_reg;

  logic          tick;
  logic          frame_load;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic [3:0]    an_next;

  // Per-digit views of the shadow state, indexed by scan position (0 = leftmost).
  logic [3:0] digit_code  [4];
  logic       digit_blank [4];
  logic       digit_dp    [4];
  logic [3:0] digit_an    [4];

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    s = 7'h00;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_code[gi]  = shadow_code_reg[15-4*gi -: 4];
      assign digit_blank[gi] = shadow_blank_reg[3-gi];
      assign digit_dp[gi]    = shadow_dp_reg[3-gi];
      assign digit_an[gi]    = 4'b1000 >> gi;
    end
  endgenerate

  assign tick       = (prescaler_reg == PRE_LAST);
  assign frame_load = tick && (idx_reg == 2'd3);

  // Internal active-high drive for the digit currently addressed by idx.
  always_comb begin
    an_next  = 4'h0;
    seg_next = 7'h00;
    dp_next  = 1'b0;
    if (!digit_blank[idx_reg]) begin
      an_next  = digit_an[idx_reg];
      seg_next = decode(digit_code[idx_reg]);
      dp_next  = digit_dp[idx_reg];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler_reg    <= '0;
      idx_reg          <= 2'd0;
      shadow_code_reg  <= 16'h0000;
      shadow_blank_reg <= 4'b1111;
      shadow_dp_reg    <= 4'b0000;
      seg_reg          <= SEG_INV;
      dp_out_reg       <= DP_INV;
      an_reg           <= AN_INV;
      frame_done_reg   <= 1'b0;
    end else begin
      prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;
      if (tick) begin
        idx_reg <= idx_reg + 2'd1;
      end
      if (frame_load) begin
        shadow_code_reg  <= display;
        shadow_blank_reg <= blank;
        shadow_dp_reg    <= dp;
      end
      seg_reg        <= seg_next ^ SEG_INV;
      dp_out_reg     <= dp_next ^ DP_INV;
      an_reg         <= an_next ^ AN_INV;
      frame_done_reg <= frame_load;
    end
  end

  assign seg        = seg_reg;
  assign dp_out     = dp_out_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=4, ACTIVE_LOW=1; one frame is 16 cycles.
module tb_seg_scan;

  logic        clk;
  logic        rst;
  logic [15:0] display;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_fails  = 0;

  seg_scan #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .display    (display),
    .blank      (blank),
    .dp         (dp),
    .seg        (seg),
    .dp_out     (dp_out),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, ".an"}, {12'h0, an}, 16'h000F);
    chk({tag, ".seg"}, {9'h0, seg}, 16'h007F);
    chk({tag, ".dp"}, {15'h0, dp_out}, 16'h0001);
  endtask

  // Checks the 16 edges of one frame. s0..s3 are the expected active-low segment
  // patterns per digit; bl/dpv are the blank/dp values in the shadow for this frame.
  // After sampling edge mid_e, new inputs are applied.
  task automatic run_frame(input string name,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] bl, input logic [3:0] dpv,
                           input int mid_e, input logic [15:0] nd,
                           input logic [3:0] nb, input logic [3:0] ndp);
    logic [6:0] segs [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         d;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int e = 1; e <= 16; e++) begin
      step();
      d = (e - 1) / 4;
      if (bl[3-d]) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_an  = ~(4'b1000 >> d);
        exp_seg = segs[d];
        exp_dp  = ~dpv[3-d];
      end
      chk($sformatf("%s.e%0d.an", name, e), {12'h0, an}, {12'h0, exp_an});
      chk($sformatf("%s.e%0d.seg", name, e), {9'h0, seg}, {9'h0, exp_seg});
      chk($sformatf("%s.e%0d.dp", name, e), {15'h0, dp_out}, {15'h0, exp_dp});
      chk($sformatf("%s.e%0d.fd", name, e), {15'h0, frame_done}, {15'h0, (e == 16)});
      if (e == mid_e) begin
        display = nd;
        blank   = nb;
        dp      = ndp;
      end
    end
    $display("frame %s checked (%0d checks so far)", name, n_checks);
  endtask

  initial begin
    rst     = 1'b0;
    display = 16'h0123;
    blank   = 4'b0000;
    dp      = 4'b0000;

    // Held in reset: dark and no frame pulse.
    for (int i = 0; i < 10; i++) begin
      step();
      chk_dark($sformatf("rst%0d", i));
      chk("rst.fd", {15'h0, frame_done}, 16'h0000);
    end
    $display("reset hold checked");
    rst = 1'b1;

    run_frame("dark0", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF, 4'h0, 0, 16'h0123, 4'h0, 4'h0);
    // 0123 shown; switch to ABCD during digit 1, which must not tear this frame.
    run_frame("f0123", 7'h40, 7'h79, 7'h24, 7'h30, 4'h0, 4'h0, 6, 16'hABCD, 4'h0, 4'h0);
    run_frame("fABCD", 7'h08, 7'h03, 7'h46, 7'h21, 4'h0, 4'h0, 3, 16'hABCD, 4'b0100, 4'h0);
    run_frame("blank1", 7'h08, 7'h03, 7'h46, 7'h21, 4'b0100, 4'h0, 3, 16'hABCD, 4'h0, 4'b1000);
    run_frame("dp0", 7'h08, 7'h03, 7'h46, 7'h21, 4'h0, 4'b1000, 0, 16'hABCD, 4'h0, 4'b1000);

    // Into digit 2 of the next frame, then assert reset between edges.
    for (int e = 1; e <= 10; e++) step();
    chk("pre_rst.an", {12'h0, an}, 16'h000D);
    chk("pre_rst.seg", {9'h0, seg}, 16'h0046);
    #2 rst = 1'b0;
    #1;
    chk_dark("async_rst");
    chk("async_rst.fd", {15'h0, frame_done}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_dark("rst_hold");
      chk("rst_hold.fd", {15'h0, frame_done}, 16'h0000);
    end
    rst = 1'b1;
    $display("mid-frame reset checked");

    run_frame("dark1", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF, 4'h0, 0, 16'hABCD, 4'h0, 4'b1000);
    run_frame("restart", 7'h08, 7'h03, 7'h46, 7'h21, 4'h0, 4'b1000, 0, 16'hABCD, 4'h0, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
